zion_dat_read_seq: RTL and testbench

- Sequencer that accepts one wide data word per request and streams selected narrow segments of it out over a valid/ready interface, one segment per accepted beat.
- Drives the segment-select path of a wide-to-narrow read datapath: it owns the segment address counter, the enable and the beat count, so requesters never drive segment addresses directly.
- Sits between a wide-word source (memory or buffer read port) and a narrow consumer.

---
 rtl/zion_dat_read_seq.sv | 114 +++++++++++
 tb/tb_zion_dat_read_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/zion_dat_read_seq.sv
// Wide-to-narrow read sequencer: captures one wide word per request and streams
// a run of its segments over a valid/ready interface, wrapping the segment pointer.
module zion_dat_read_seq #(
  parameter  int WIDTH_DATA_IN  = 64,
  parameter  int WIDTH_DATA_OUT = 16,
  localparam int NUM_SEG        = WIDTH_DATA_IN / WIDTH_DATA_OUT,
  localparam int WIDTH_SEG      = $clog2(NUM_SEG)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iReqVld,
  output logic                      oReqRdy,
  input  logic [WIDTH_DATA_IN-1:0]  iReqDat,
  input  logic [WIDTH_SEG-1:0]      iReqStart,
  input  logic [WIDTH_SEG-1:0]      iReqLen,
  input  logic                      iAbort,
  output logic                      oDatVld,
  input  logic                      iDatRdy,
  output logic [WIDTH_DATA_OUT-1:0] oDat,
  output logic                      oDatLast,
  output logic [WIDTH_SEG-1:0]      oSegIdx,
  output logic                      oBusy
);

  localparam logic [WIDTH_SEG-1:0] LAST_SEG = WIDTH_SEG'(NUM_SEG - 1);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e                     state_q, state_d;
  logic [WIDTH_DATA_IN-1:0]   word_q, word_d;
  logic [WIDTH_SEG-1:0]       ptr_q, ptr_d;
  logic [WIDTH_SEG-1:0]       rem_q, rem_d;

  logic                       in_send;
  logic                       last_beat;
  logic                       req_fire;
  logic                       beat_fire;
  logic [WIDTH_DATA_OUT-1:0]  seg_arr [NUM_SEG];
  logic [WIDTH_DATA_OUT-1:0]  seg_sel;

  assign in_send   = (state_q == ST_SEND);
  assign last_beat = in_send && (rem_q == '0);
  assign req_fire  = iReqVld && oReqRdy;
  assign beat_fire = in_send && iDatRdy;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg
      assign seg_arr[gi] = word_q[gi*WIDTH_DATA_OUT +: WIDTH_DATA_OUT];
    end
  endgenerate

  // Compare-based mux so NUM_SEG need not be a power of two.
  always_comb begin
    seg_sel = '0;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (ptr_q == WIDTH_SEG'(k)) seg_sel = seg_arr[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      word_q  <= '0;
      ptr_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (iAbort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (req_fire) state_d = ST_SEND;
        ST_SEND: if (beat_fire && last_beat && !req_fire) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A request landing on the last beat reloads everything and keeps streaming.
  always_comb begin
    word_d = word_q;
    ptr_d  = ptr_q;
    rem_d  = rem_q;
    if (!iAbort) begin
      if (req_fire) begin
        word_d = iReqDat;
        ptr_d  = iReqStart;
        rem_d  = iReqLen;
      end else if (beat_fire && !last_beat) begin
        ptr_d = (ptr_q == LAST_SEG) ? '0 : ptr_q + WIDTH_SEG'(1);
        rem_d = rem_q - WIDTH_SEG'(1);
      end
    end
  end

  always_comb begin
    oDatVld  = in_send;
    oBusy    = in_send;
    oDatLast = last_beat;
    oSegIdx  = ptr_q;
    oDat     = in_send ? seg_sel : '0;
    oReqRdy  = rst_n && !iAbort && (in_send ? (iDatRdy && last_beat) : 1'b1);
  end

endmodule

// File: tb/tb_zion_dat_read_seq.sv
// Bench for zion_dat_read_seq: directed scenarios then random traffic, all
// checked against a queue-of-expected-beats model built from each request.
module tb_zion_dat_read_seq;

  localparam int WIN  = 64;
  localparam int WOUT = 16;
  localparam int NSEG = WIN / WOUT;
  localparam int WSEG = $clog2(NSEG);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iReqVld;
  logic            oReqRdy;
  logic [WIN-1:0]  iReqDat;
  logic [WSEG-1:0] iReqStart;
  logic [WSEG-1:0] iReqLen;
  logic            iAbort;
  logic            oDatVld;
  logic            iDatRdy;
  logic [WOUT-1:0] oDat;
  logic            oDatLast;
  logic [WSEG-1:0] oSegIdx;
  logic            oBusy;

  zion_dat_read_seq #(.WIDTH_DATA_IN(WIN), .WIDTH_DATA_OUT(WOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .iReqVld(iReqVld), .oReqRdy(oReqRdy), .iReqDat(iReqDat),
    .iReqStart(iReqStart), .iReqLen(iReqLen), .iAbort(iAbort),
    .oDatVld(oDatVld), .iDatRdy(iDatRdy), .oDat(oDat),
    .oDatLast(oDatLast), .oSegIdx(oSegIdx), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WOUT-1:0] dat;
    logic [WSEG-1:0] idx;
    logic            last;
  } beat_t;

  beat_t exp_q[$];
  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Spell out every beat a request should produce, in order.
  task automatic push_request(input logic [WIN-1:0] w, input logic [WSEG-1:0] st, input logic [WSEG-1:0] ln);
    beat_t b;
    int idx;
    exp_q.delete();
    for (int i = 0; i <= int'(ln); i++) begin
      idx    = (int'(st) + i) % NSEG;
      b.dat  = WOUT'(w >> (idx * WOUT));
      b.idx  = WSEG'(idx);
      b.last = (i == int'(ln));
      exp_q.push_back(b);
    end
  endtask

  // Apply inputs for one cycle, check outputs at the falling edge, advance the model.
  task automatic run_cycle(input logic vld, input logic [WIN-1:0] dat, input logic [WSEG-1:0] st,
                           input logic [WSEG-1:0] ln, input logic ab, input logic rdy);
    logic exp_vld, exp_rdy;
    iReqVld = vld; iReqDat = dat; iReqStart = st; iReqLen = ln; iAbort = ab; iDatRdy = rdy;
    assert (!(vld && int'(st) >= NSEG)) else $error("illegal request start %0d", st);
    @(negedge clk);
    exp_vld = (exp_q.size() > 0);
    exp_rdy = !ab && (!exp_vld || (rdy && exp_q[0].last));
    chk("dat_vld", 64'(oDatVld), 64'(exp_vld));
    chk("busy", 64'(oBusy), 64'(exp_vld));
    chk("req_rdy", 64'(oReqRdy), 64'(exp_rdy));
    if (exp_vld) begin
      chk("dat", 64'(oDat), 64'(exp_q[0].dat));
      chk("seg_idx", 64'(oSegIdx), 64'(exp_q[0].idx));
      chk("dat_last", 64'(oDatLast), 64'(exp_q[0].last));
    end
    txn++;
    $display("txn %0d: vld=%0b rdy=%0b abort=%0b -> dat_vld=%0b dat=%h idx=%0d last=%0b req_rdy=%0b",
             txn, vld, rdy, ab, oDatVld, oDat, oSegIdx, oDatLast, oReqRdy);
    if (ab) begin
      exp_q.delete();
    end else begin
      if (exp_vld && rdy) void'(exp_q.pop_front());
      if (vld && exp_rdy) push_request(dat, st, ln);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle(input logic rdy);
    run_cycle(1'b0, '0, '0, '0, 1'b0, rdy);
  endtask

  task automatic expect_beat(input string tag, input logic [WOUT-1:0] d, input logic [WSEG-1:0] idx, input logic last);
    chk({tag, "_vld"}, 64'(oDatVld), 64'(1));
    chk({tag, "_dat"}, 64'(oDat), 64'(d));
    chk({tag, "_idx"}, 64'(oSegIdx), 64'(idx));
    chk({tag, "_last"}, 64'(oDatLast), 64'(last));
  endtask

  task automatic scenario_full(input string tag);
    logic [WIN-1:0] w;
    w = 64'h4444_3333_2222_1111;
    run_cycle(1'b1, w, 2'd0, 2'd3, 1'b0, 1'b1);
    expect_beat({tag, "_b0"}, 16'h1111, 2'd0, 1'b0);
    idle_cycle(1'b1);
    expect_beat({tag, "_b1"}, 16'h2222, 2'd1, 1'b0);
    idle_cycle(1'b1);
    expect_beat({tag, "_b2"}, 16'h3333, 2'd2, 1'b0);
    idle_cycle(1'b1);
    expect_beat({tag, "_b3"}, 16'h4444, 2'd3, 1'b1);
    idle_cycle(1'b1);
    chk({tag, "_idle_vld"}, 64'(oDatVld), 64'(0));
    idle_cycle(1'b1);
  endtask

  logic [WIN-1:0] rw;
  logic           rvld, rab, rrdy;
  logic [WSEG-1:0] rst_v, rln;

  initial begin
    rst_n = 1'b0;
    iReqVld = 1'b0; iReqDat = '0; iReqStart = '0; iReqLen = '0; iAbort = 1'b0; iDatRdy = 1'b0;
    #2;
    chk("rst_dat_vld", 64'(oDatVld), 64'(0));
    chk("rst_req_rdy", 64'(oReqRdy), 64'(0));
    chk("rst_dat", 64'(oDat), 64'(0));
    chk("rst_seg_idx", 64'(oSegIdx), 64'(0));
    chk("rst_last", 64'(oDatLast), 64'(0));
    chk("rst_busy", 64'(oBusy), 64'(0));
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    scenario_full("full");

    // Wrap around the top segment.
    run_cycle(1'b1, 64'h4444_3333_2222_1111, 2'd2, 2'd3, 1'b0, 1'b1);
    expect_beat("wrap_b0", 16'h3333, 2'd2, 1'b0);
    idle_cycle(1'b1);
    expect_beat("wrap_b1", 16'h4444, 2'd3, 1'b0);
    idle_cycle(1'b1);
    expect_beat("wrap_b2", 16'h1111, 2'd0, 1'b0);
    idle_cycle(1'b1);
    expect_beat("wrap_b3", 16'h2222, 2'd1, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Backpressure holds the first beat.
    run_cycle(1'b1, 64'h4444_3333_2222_1111, 2'd1, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_beat("bp_hold", 16'h2222, 2'd1, 1'b0);
      idle_cycle(1'b0);
    end
    expect_beat("bp_b0", 16'h2222, 2'd1, 1'b0);
    idle_cycle(1'b1);
    expect_beat("bp_b1", 16'h3333, 2'd2, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Back-to-back: second request held valid, accepted only on the last beat.
    run_cycle(1'b1, 64'h4444_3333_2222_1111, 2'd0, 2'd1, 1'b0, 1'b1);
    chk("b2b_rdy_first", 64'(oReqRdy), 64'(0));
    run_cycle(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 2'd0, 2'd0, 1'b0, 1'b1);
    expect_beat("b2b_last", 16'h2222, 2'd1, 1'b1);
    run_cycle(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 2'd0, 2'd0, 1'b0, 1'b1);
    expect_beat("b2b_new", 16'hAAAA, 2'd0, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    // Abort during beat 2 of a four-beat request.
    run_cycle(1'b1, 64'h4444_3333_2222_1111, 2'd0, 2'd3, 1'b0, 1'b1);
    idle_cycle(1'b1);
    expect_beat("abort_b1", 16'h2222, 2'd1, 1'b0);
    run_cycle(1'b0, '0, '0, '0, 1'b1, 1'b1);
    chk("abort_vld", 64'(oDatVld), 64'(0));
    chk("abort_busy", 64'(oBusy), 64'(0));
    run_cycle(1'b1, 64'hDDDD_CCCC_BBBB_AAAA, 2'd3, 2'd0, 1'b0, 1'b1);
    expect_beat("abort_new", 16'hDDDD, 2'd3, 1'b1);
    idle_cycle(1'b1);

    // Asynchronous reset in the middle of SEND.
    run_cycle(1'b1, 64'h4444_3333_2222_1111, 2'd0, 2'd3, 1'b0, 1'b1);
    idle_cycle(1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(oDatVld), 64'(0));
    chk("mid_rst_dat", 64'(oDat), 64'(0));
    chk("mid_rst_busy", 64'(oBusy), 64'(0));
    chk("mid_rst_rdy", 64'(oReqRdy), 64'(0));
    exp_q.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    scenario_full("post_rst");

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rw    = {$urandom, $urandom};
      rvld  = ($urandom_range(0, 1) == 1);
      rst_v = WSEG'($urandom_range(0, NSEG - 1));
      rln   = WSEG'($urandom_range(0, (1 << WSEG) - 1));
      rab   = ($urandom_range(0, 19) == 0);
      rrdy  = ($urandom_range(0, 9) < 7);
      run_cycle(rvld, rw, rst_v, rln, rab, rrdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
